cp0_unit: RTL and testbench

Coprocessor-0 for the pipelined MIPS core: holds SR, Cause, EPC and PRId; detects enabled hardware interrupts; and captures the return PC when the controller takes an interrupt. On `eret` it supplies EPC to the next-PC selector, and it supplies EXL-clear; it is the state-holding counterpart of the next-PC selector's exception/return paths. It sits beside the register file, is accessed by `mfc0`/`mtc0`, and drives `int_req` to the controller.

---
 rtl/cp0_pkg.sv | 49 ++++
 rtl/cp0_irq_detect.sv | 60 ++++++
 rtl/cp0_unit.sv | 117 +++++++++++
 tb/tb_cp0_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the coprocessor-0 block.
//   - CP0 register numbers (SR, Cause, EPC, PRId)
//   - SR / Cause field bit positions
//   - Interrupt vector word address, also used by the next-PC selector
// Optional feature macro used by cp0_irq_detect: CP0_IP_LATCH_EN.
package cp0_pkg;

    // CP0 register numbers (rd field of mfc0/mtc0)
    localparam logic [4:0] RegSr    = 5'd12;
    localparam logic [4:0] RegCause = 5'd13;
    localparam logic [4:0] RegEpc   = 5'd14;
    localparam logic [4:0] RegPrid  = 5'd15;

    // SR fields
    localparam int unsigned SrIeBit  = 0;
    localparam int unsigned SrExlBit = 1;
    localparam int unsigned SrImLo   = 10;
    localparam int unsigned SrImHi   = 15;

    // Cause fields
    localparam int unsigned CauseIpLo = 10;
    localparam int unsigned CauseIpHi = 15;

    localparam int unsigned NumHwInt = 6;

    // Interrupt vector, word address (byte address 0x0000_4180)
    localparam logic [29:0] IntVector = 30'h0000_1060;

    // Pack the visible SR bits into a 32-bit read value.
    function automatic logic [31:0] pack_sr(input logic [NumHwInt-1:0] im,
                                            input logic exl,
                                            input logic ie);
        logic [31:0] v;
        v = '0;
        v[SrImHi:SrImLo] = im;
        v[SrExlBit]      = exl;
        v[SrIeBit]       = ie;
        return v;
    endfunction

    // Pack the visible Cause bits into a 32-bit read value.
    function automatic logic [31:0] pack_cause(input logic [NumHwInt-1:0] ip);
        logic [31:0] v;
        v = '0;
        v[CauseIpHi:CauseIpLo] = ip;
        return v;
    endfunction

endpackage

// File: rtl/cp0_irq_detect.sv
// cp0_irq_detect: interrupt-pending register and request equation.
// Configuration macro: CP0_IP_LATCH_EN
//   defined   - IP bits are sticky; set by hwint, cleared only by an mtc0 to Cause writing 0
//               (a set in the same cycle wins over the clear).
//   undefined - IP mirrors hwint every cycle; mtc0 to Cause has no effect.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   hwint_i         - level-sensitive device interrupt lines (Cause IP[15:10] order)
//   cause_we_i      - mtc0 to Cause this cycle
//   cause_wdata_i   - IP field of the mtc0 write data
//   im_i, ie_i, exl_i - registered SR fields
//   ip_o            - registered IP bits
//   int_req_o       - interrupt request to the controller
module cp0_irq_detect
    import cp0_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NumHwInt-1:0] hwint_i,
    input  logic                cause_we_i,
    input  logic [NumHwInt-1:0] cause_wdata_i,
    input  logic [NumHwInt-1:0] im_i,
    input  logic                ie_i,
    input  logic                exl_i,
    output logic [NumHwInt-1:0] ip_o,
    output logic                int_req_o
);

    logic [NumHwInt-1:0] ip_d, ip_q;

`ifdef CP0_IP_LATCH_EN
    always_comb begin
        ip_d = ip_q;
        // Software clear applied first so a concurrent hwint set wins.
        if (cause_we_i) begin
            ip_d = ip_q & cause_wdata_i;
        end
        ip_d = ip_d | hwint_i;
    end
`else
    logic unused_cause_wr;
    assign unused_cause_wr = cause_we_i ^ (^cause_wdata_i);

    always_comb begin
        ip_d = hwint_i;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ip_q <= '0;
        end else begin
            ip_q <= ip_d;
        end
    end

    assign ip_o      = ip_q;
    assign int_req_o = (|(ip_q & im_i)) & ie_i & ~exl_i;

endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor 0 for the pipelined MIPS core.
// Holds SR (12), Cause (13), EPC (14) and PRId (15); raises int_req to the controller and
// captures the resume PC when an interrupt is taken.
// Configuration macro: CP0_IP_LATCH_EN (sticky IP bits, see cp0_irq_detect).
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   rd_addr   - mfc0 register number;  dout - combinational mfc0 read data
//   wr_addr, din, we - mtc0 register number, data, enable
//   pc        - word PC to resume at, captured into EPC on exl_set
//   exl_set   - controller takes an interrupt;  exl_clr - eret executing
//   hwint     - device interrupt lines [7:2]
//   epc       - EPC to the next-PC selector;  int_req - interrupt request
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rd_addr,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] din,
    input  logic        we,
    input  logic [31:2] pc,
    input  logic        exl_set,
    input  logic        exl_clr,
    input  logic [7:2]  hwint,
    output logic [31:0] dout,
    output logic [31:2] epc,
    output logic        int_req
);

    logic [NumHwInt-1:0] im_d, im_q;
    logic                ie_d, ie_q;
    logic                exl_d, exl_q;
    logic [29:0]         epc_d, epc_q;
    logic [NumHwInt-1:0] ip;

    logic sr_we, cause_we, epc_we;

    assign sr_we    = we && (wr_addr == RegSr);
    assign cause_we = we && (wr_addr == RegCause);
    assign epc_we   = we && (wr_addr == RegEpc);

    // Only the mapped fields of din are ever stored.
    logic unused_din;
    assign unused_din = ^{din[SrExlBit], din[9:2]};

    always_comb begin
        im_d  = im_q;
        ie_d  = ie_q;
        exl_d = exl_q;
        epc_d = epc_q;

        if (sr_we) begin
            im_d = din[SrImHi:SrImLo];
            ie_d = din[SrIeBit];
        end

        // Hardware EXL updates override whatever software wrote to that bit.
        if (exl_set) begin
            exl_d = 1'b1;
        end else if (exl_clr) begin
            exl_d = 1'b0;
        end else if (sr_we) begin
            exl_d = din[SrExlBit];
        end

        if (exl_set) begin
            epc_d = pc;
        end else if (epc_we) begin
            epc_d = din[31:2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            im_q  <= '0;
            ie_q  <= 1'b0;
            exl_q <= 1'b0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            ie_q  <= ie_d;
            exl_q <= exl_d;
            epc_q <= epc_d;
        end
    end

    cp0_irq_detect u_irq_detect (
        .clk           (clk),
        .rst           (rst),
        .hwint_i       (hwint),
        .cause_we_i    (cause_we),
        .cause_wdata_i (din[CauseIpHi:CauseIpLo]),
        .im_i          (im_q),
        .ie_i          (ie_q),
        .exl_i         (exl_q),
        .ip_o          (ip),
        .int_req_o     (int_req)
    );

    // Reads see registered state only, so a same-cycle write returns the old value.
    always_comb begin
        dout = '0;
        case (rd_addr)
            RegSr:    dout = pack_sr(im_q, exl_q, ie_q);
            RegCause: dout = pack_cause(ip);
            RegEpc:   dout = {epc_q, 2'b00};
            RegPrid:  dout = PRID;
            default:  dout = '0;
        endcase
    end

    assign epc = epc_q;

endmodule

// File: tb/tb_cp0_unit.sv
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr;
    logic [4:0]  wr_addr;
    logic [31:0] din;
    logic        we;
    logic [31:2] pc;
    logic        exl_set;
    logic        exl_clr;
    logic [7:2]  hwint;
    logic [31:0] dout;
    logic [31:2] epc;
    logic        int_req;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cp0_unit #(.PRID(32'h0000_0001)) dut (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (rd_addr),
        .wr_addr (wr_addr),
        .din     (din),
        .we      (we),
        .pc      (pc),
        .exl_set (exl_set),
        .exl_clr (exl_clr),
        .hwint   (hwint),
        .dout    (dout),
        .epc     (epc),
        .int_req (int_req)
    );

    // Advance one rising edge; inputs are changed 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we      = 1'b0;
        wr_addr = 5'd0;
        din     = 32'h0;
        exl_set = 1'b0;
        exl_clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_rd [4];
        exp_rd = '{32'h0, 32'h0, 32'h0, 32'h0000_0001};
        rst = 1'b1; idle_inputs(); pc = '0; hwint = '0; rd_addr = 5'd12;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_addr = 5'(12 + i);
            #1;
            n_checks++;
            if (dout !== exp_rd[i]) begin
                n_fail++;
                $display("FAIL reset_mfc0_%0d: got %h expected %h", 12 + i, dout, exp_rd[i]);
            end
        end
        n_checks++;
        if (int_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_int_req: got %b expected 0", int_req);
        end
        n_checks++;
        if (epc !== 30'h0) begin
            n_fail++; $display("FAIL reset_epc: got %h expected 0", epc);
        end
    endtask

    task automatic test_mtc0();
        we = 1'b1; wr_addr = 5'd12; din = 32'h0000_0401; rd_addr = 5'd12;
        #1;
        n_checks++;
        if (dout !== 32'h0) begin
            n_fail++; $display("FAIL rdw_old_sr: got %h expected 00000000", dout);
        end
        tick();
        // PRId write must be ignored
        wr_addr = 5'd15; din = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (dout !== 32'h0000_0401) begin
            n_fail++; $display("FAIL mtc0_sr: got %h expected 00000401", dout);
        end
        rd_addr = 5'd15; #1;
        n_checks++;
        if (dout !== 32'h0000_0001) begin
            n_fail++; $display("FAIL prid_ro: got %h expected 00000001", dout);
        end
        n_checks++;
        if (int_req !== 1'b0) begin
            n_fail++; $display("FAIL no_irq_yet: got %b expected 0", int_req);
        end
    endtask

    task automatic test_irq();
        hwint = 6'b000001;
        #1;
        n_checks++;
        if (int_req !== 1'b0) begin
            n_fail++; $display("FAIL irq_before_edge: got %b expected 0", int_req);
        end
        tick();
        n_checks++;
        if (int_req !== 1'b1) begin
            n_fail++; $display("FAIL irq_after_edge: got %b expected 1", int_req);
        end
        rd_addr = 5'd13; #1;
        n_checks++;
        if (dout !== 32'h0000_0400) begin
            n_fail++; $display("FAIL cause_ip2: got %h expected 00000400", dout);
        end
    endtask

    task automatic test_exl_set();
        pc = 30'h0000_0C05; exl_set = 1'b1;
        tick();
        exl_set = 1'b0;
        #1;
        n_checks++;
        if (epc !== 30'h0000_0C05) begin
            n_fail++; $display("FAIL exl_set_epc: got %h expected 00000c05", epc);
        end
        rd_addr = 5'd14; #1;
        n_checks++;
        if (dout !== 32'h0000_3014) begin
            n_fail++; $display("FAIL mfc0_epc: got %h expected 00003014", dout);
        end
        rd_addr = 5'd12; #1;
        n_checks++;
        if (dout !== 32'h0000_0403) begin
            n_fail++; $display("FAIL sr_exl: got %h expected 00000403", dout);
        end
        n_checks++;
        if (int_req !== 1'b0) begin
            n_fail++; $display("FAIL irq_masked_exl: got %b expected 0", int_req);
        end
    endtask

    task automatic test_exl_clr();
        exl_clr = 1'b1; #1;
        n_checks++;
        if (epc !== 30'h0000_0C05) begin
            n_fail++; $display("FAIL eret_epc: got %h expected 00000c05", epc);
        end
        tick();
        exl_clr = 1'b0; rd_addr = 5'd12; #1;
        n_checks++;
        if (dout !== 32'h0000_0401) begin
            n_fail++; $display("FAIL exl_clr_sr: got %h expected 00000401", dout);
        end
        n_checks++;
        if (int_req !== 1'b1) begin
            n_fail++; $display("FAIL irq_reasserts: got %b expected 1", int_req);
        end
    endtask

    task automatic test_priority();
        // set + clr + mtc0 EPC together: set wins on both EXL and EPC
        pc = 30'h0000_0ABC; exl_set = 1'b1; exl_clr = 1'b1;
        we = 1'b1; wr_addr = 5'd14; din = 32'h0000_1000;
        tick();
        idle_inputs(); rd_addr = 5'd12; #1;
        n_checks++;
        if (epc !== 30'h0000_0ABC) begin
            n_fail++; $display("FAIL prio_epc: got %h expected 00000abc", epc);
        end
        n_checks++;
        if (dout !== 32'h0000_0403) begin
            n_fail++; $display("FAIL prio_exl: got %h expected 00000403", dout);
        end
        // SR write with exl_clr: IM/IE from din, EXL cleared despite din[1]=1
        we = 1'b1; wr_addr = 5'd12; din = 32'h0000_8003; exl_clr = 1'b1;
        tick();
        idle_inputs(); #1;
        n_checks++;
        if (dout !== 32'h0000_8001) begin
            n_fail++; $display("FAIL sr_wr_with_clr: got %h expected 00008001", dout);
        end
        n_checks++;
        if (int_req !== 1'b0) begin
            n_fail++; $display("FAIL irq_im_mismatch: got %b expected 0", int_req);
        end
        // SR write with exl_set: EXL set despite din[1]=0
        we = 1'b1; wr_addr = 5'd12; din = 32'h0000_0401; exl_set = 1'b1;
        tick();
        idle_inputs(); #1;
        n_checks++;
        if (dout !== 32'h0000_0403) begin
            n_fail++; $display("FAIL sr_wr_with_set: got %h expected 00000403", dout);
        end
        // plain mtc0 to EPC
        we = 1'b1; wr_addr = 5'd14; din = 32'h0000_1000;
        tick();
        idle_inputs(); rd_addr = 5'd14; #1;
        n_checks++;
        if (dout !== 32'h0000_1000 || epc !== 30'h0000_0400) begin
            n_fail++; $display("FAIL mtc0_epc: got %h/%h expected 00001000/00000400", dout, epc);
        end
    endtask

    task automatic test_ip_latch();
        logic [31:0] exp_held;
`ifdef CP0_IP_LATCH_EN
        exp_held = 32'h0000_0800;
`else
        exp_held = 32'h0000_0000;
`endif
        hwint = '0; we = 1'b1; wr_addr = 5'd13; din = 32'h0;
        tick();
        idle_inputs(); rd_addr = 5'd13; #1;
        n_checks++;
        if (dout !== 32'h0) begin
            n_fail++; $display("FAIL cause_cleared: got %h expected 00000000", dout);
        end
        hwint = 6'b000010;
        tick();
        hwint = '0; #1;
        n_checks++;
        if (dout !== 32'h0000_0800) begin
            n_fail++; $display("FAIL cause_ip3: got %h expected 00000800", dout);
        end
        tick(); tick();
        n_checks++;
        if (dout !== exp_held) begin
            n_fail++; $display("FAIL cause_after_pulse: got %h expected %h", dout, exp_held);
        end
        // writing 1s never sets IP
        we = 1'b1; wr_addr = 5'd13; din = 32'h0000_FC00;
        tick();
        idle_inputs(); #1;
        n_checks++;
        if (dout !== exp_held) begin
            n_fail++; $display("FAIL cause_write_ones: got %h expected %h", dout, exp_held);
        end
        // concurrent set and clear on bit 3: set wins (and mirror also shows 1)
        hwint = 6'b000010; we = 1'b1; wr_addr = 5'd13; din = 32'h0;
        tick();
        idle_inputs(); hwint = '0; #1;
        n_checks++;
        if (dout !== 32'h0000_0800) begin
            n_fail++; $display("FAIL cause_set_wins: got %h expected 00000800", dout);
        end
        we = 1'b1; wr_addr = 5'd13; din = 32'h0;
        tick();
        idle_inputs(); #1;
        n_checks++;
        if (dout !== 32'h0) begin
            n_fail++; $display("FAIL cause_sw_clear: got %h expected 00000000", dout);
        end
    endtask

    task automatic test_mask_and_unmapped();
        we = 1'b1; wr_addr = 5'd12; din = 32'h0000_0401; exl_clr = 1'b1; hwint = 6'b000001;
        tick();
        idle_inputs(); #1;
        n_checks++;
        if (int_req !== 1'b1) begin
            n_fail++; $display("FAIL mask_irq_on: got %b expected 1", int_req);
        end
        we = 1'b1; wr_addr = 5'd12; din = 32'h0000_0400;
        tick();
        idle_inputs(); #1;
        n_checks++;
        if (int_req !== 1'b0) begin
            n_fail++; $display("FAIL mask_ie_off: got %b expected 0", int_req);
        end
        // write to unmapped address leaves SR alone
        we = 1'b1; wr_addr = 5'd5; din = 32'hFFFF_FFFF;
        tick();
        idle_inputs(); rd_addr = 5'd12; #1;
        n_checks++;
        if (dout !== 32'h0000_0400) begin
            n_fail++; $display("FAIL unmapped_write: got %h expected 00000400", dout);
        end
        rd_addr = 5'd5; #1;
        n_checks++;
        if (dout !== 32'h0) begin
            n_fail++; $display("FAIL unmapped_read: got %h expected 00000000", dout);
        end
    endtask

    task automatic test_reset_mid_handler();
        we = 1'b1; wr_addr = 5'd12; din = 32'h0000_0401; exl_set = 1'b1; pc = 30'h0000_0123;
        tick();
        idle_inputs(); rst = 1'b1;
        tick();
        rst = 1'b0; rd_addr = 5'd12; #1;
        n_checks++;
        if (dout !== 32'h0 || epc !== 30'h0) begin
            n_fail++; $display("FAIL reset_mid_handler: got sr=%h epc=%h expected 0/0", dout, epc);
        end
    endtask

    initial begin
        test_reset();
        test_mtc0();
        test_irq();
        test_exl_set();
        test_exl_clr();
        test_priority();
        test_ip_latch();
        test_mask_and_unmapped();
        test_reset_mid_handler();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
